// File: rtl/layer_sequencer.sv
// Address sequencer for one fully-connected layer: walks every (input, output)
// neuron pair, drives MAC operand addresses, then drains the MAC pipeline.
module layer_sequencer #(
  parameter int N_IN       = 784,
  parameter int N_OUT      = 16,
  parameter int PIPE_DEPTH = 3,
  parameter int W_BASE     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  output logic [11:0] in_addr,
  output logic [15:0] weight_addr,
  output logic        issue,
  output logic        reset_mult_acc,
  output logic [11:0] out_neuron_addr,
  output logic        last_in,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [11:0] I_LAST = 12'(N_IN - 1);
  localparam logic [11:0] O_LAST = 12'(N_OUT - 1);
  localparam logic [15:0] W_INIT = 16'(W_BASE);
  localparam logic [3:0]  D_LAST = 4'(PIPE_DEPTH - 1);

  state_t      state, state_n;
  logic [11:0] i, i_n, o, o_n;
  logic [15:0] wcnt, wcnt_n;
  logic [3:0]  dcnt, dcnt_n;

  logic [11:0] in_addr_n, out_neuron_addr_n;
  logic [15:0] weight_addr_n;
  logic        issue_n, reset_mult_acc_n, last_in_n, busy_n, done_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      i               <= '0;
      o               <= '0;
      wcnt            <= W_INIT;
      dcnt            <= '0;
      in_addr         <= '0;
      weight_addr     <= '0;
      out_neuron_addr <= '0;
      issue           <= 1'b0;
      reset_mult_acc  <= 1'b0;
      last_in         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_n;
      i               <= i_n;
      o               <= o_n;
      wcnt            <= wcnt_n;
      dcnt            <= dcnt_n;
      in_addr         <= in_addr_n;
      weight_addr     <= weight_addr_n;
      out_neuron_addr <= out_neuron_addr_n;
      issue           <= issue_n;
      reset_mult_acc  <= reset_mult_acc_n;
      last_in         <= last_in_n;
      busy            <= busy_n;
      done            <= done_n;
    end
  end

  // Weight address is a running counter: W_BASE + o*N_IN + i without a multiplier.
  always_comb begin
    state_n           = state;
    i_n               = i;
    o_n               = o;
    wcnt_n            = wcnt;
    dcnt_n            = dcnt;
    in_addr_n         = in_addr;
    weight_addr_n     = weight_addr;
    out_neuron_addr_n = out_neuron_addr;
    issue_n           = 1'b0;
    reset_mult_acc_n  = 1'b0;
    last_in_n         = 1'b0;
    busy_n            = 1'b0;
    done_n            = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          i_n     = '0;
          o_n     = '0;
          wcnt_n  = W_INIT;
        end
      end
      RUN: begin
        busy_n = 1'b1;
        if (!stall) begin
          issue_n           = 1'b1;
          in_addr_n         = i;
          out_neuron_addr_n = o;
          weight_addr_n     = wcnt;
          reset_mult_acc_n  = (i == '0);
          last_in_n         = (i == I_LAST);
          wcnt_n            = wcnt + 16'd1;
          if (i == I_LAST) begin
            i_n = '0;
            if (o == O_LAST) begin
              o_n     = '0;
              dcnt_n  = '0;
              state_n = DRAIN;
            end else begin
              o_n = o + 12'd1;
            end
          end else begin
            i_n = i + 12'd1;
          end
        end
      end
      DRAIN: begin
        busy_n = 1'b1;
        if (dcnt == D_LAST) begin
          dcnt_n  = '0;
          state_n = DONE;
        end else begin
          dcnt_n = dcnt + 4'd1;
        end
      end
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: a 4x3 layer with PIPE_DEPTH=2 and a 2x1 layer
// with PIPE_DEPTH=1, both at weight base 0x100.
module tb_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        s_start = 1'b0;

  logic [11:0] in_addr, out_neuron_addr;
  logic [15:0] weight_addr;
  logic        issue, reset_mult_acc, last_in, busy, done;

  logic [11:0] s_in_addr, s_out_neuron_addr;
  logic [15:0] s_weight_addr;
  logic        s_issue, s_reset_mult_acc, s_last_in, s_busy, s_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  layer_sequencer #(.N_IN(4), .N_OUT(3), .PIPE_DEPTH(2), .W_BASE(16'h100)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .in_addr(in_addr), .weight_addr(weight_addr), .issue(issue),
    .reset_mult_acc(reset_mult_acc), .out_neuron_addr(out_neuron_addr),
    .last_in(last_in), .busy(busy), .done(done)
  );

  layer_sequencer #(.N_IN(2), .N_OUT(1), .PIPE_DEPTH(1), .W_BASE(16'h100)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .stall(1'b0),
    .in_addr(s_in_addr), .weight_addr(s_weight_addr), .issue(s_issue),
    .reset_mult_acc(s_reset_mult_acc), .out_neuron_addr(s_out_neuron_addr),
    .last_in(s_last_in), .busy(s_busy), .done(s_done)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step;
    step;
    n_cmp++;
    if ({issue, reset_mult_acc, last_in, busy, done, in_addr, out_neuron_addr, weight_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got iss=%b rst=%b last=%b busy=%b done=%b in=%h out=%h w=%h, want all 0",
               issue, reset_mult_acc, last_in, busy, done, in_addr, out_neuron_addr, weight_addr);
    end
    n_cmp++;
    if ({s_issue, s_reset_mult_acc, s_last_in, s_busy, s_done, s_in_addr, s_out_neuron_addr, s_weight_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_state_small: got iss=%b w=%h busy=%b, want all 0", s_issue, s_weight_addr, s_busy);
    end
    reset = 1'b0;
    step;
  endtask

  // One 4x3 layer; stall is held high for RUN cycles st0..st1-1 (cycle 1 = first RUN cycle).
  task automatic run_layer(input string name, input int st0, input int st1);
    int k = 0;
    int done_cyc = -1;
    int ndone = 0;
    int nrst = 0;
    int last_iss = -1;
    logic [15:0] exp_w;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int cyc = 1; cyc <= 60 && !(done_cyc > 0 && cyc > done_cyc + 2); cyc++) begin
      stall = (cyc >= st0 && cyc < st1);
      step;
      if (reset_mult_acc) nrst++;
      if (issue) begin
        exp_w = 16'h100 + 16'(k);
        n_cmp++;
        if ({in_addr, out_neuron_addr, weight_addr, reset_mult_acc, last_in, busy} !==
            {12'(k % 4), 12'(k / 4), exp_w, (k % 4 == 0), (k % 4 == 3), 1'b1}) begin
          n_bad++;
          $display("FAIL %s issue%0d: got in=%h out=%h w=%h rst=%b last=%b busy=%b, want in=%h out=%h w=%h rst=%b last=%b busy=1",
                   name, k + 1, in_addr, out_neuron_addr, weight_addr, reset_mult_acc, last_in, busy,
                   12'(k % 4), 12'(k / 4), exp_w, (k % 4 == 0), (k % 4 == 3));
        end
        k++;
        last_iss = cyc + 1;
      end else if (k > 0 && k < 12) begin
        exp_w = 16'h100 + 16'(k - 1);
        n_cmp++;
        if (weight_addr !== exp_w || in_addr !== 12'((k - 1) % 4) || reset_mult_acc || last_in || !busy) begin
          n_bad++;
          $display("FAIL %s hold: got w=%h in=%h rst=%b last=%b busy=%b, want w=%h in=%h rst=0 last=0 busy=1",
                   name, weight_addr, in_addr, reset_mult_acc, last_in, busy, exp_w, 12'((k - 1) % 4));
        end
      end
      if (done) begin
        ndone++;
        done_cyc = cyc + 1;
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL %s busy_at_done: got %b want 0", name, busy);
        end
      end
    end
    stall = 1'b0;
    n_cmp++;
    if (k !== 12) begin n_bad++; $display("FAIL %s issue_count: got %0d want 12", name, k); end
    n_cmp++;
    if (nrst !== 3) begin n_bad++; $display("FAIL %s rst_count: got %0d want 3", name, nrst); end
    n_cmp++;
    if (ndone !== 1) begin n_bad++; $display("FAIL %s done_count: got %0d want 1", name, ndone); end
    n_cmp++;
    if (done_cyc !== 16 + (st1 - st0)) begin
      n_bad++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, 16 + (st1 - st0));
    end
    n_cmp++;
    if (done_cyc - last_iss !== 3) begin
      n_bad++;
      $display("FAIL %s drain_gap: got %0d want 3", name, done_cyc - last_iss);
    end
  endtask

  task automatic test_basic;
    run_layer("basic", 0, 0);
  endtask

  task automatic test_stall_mid;
    run_layer("stall_mid", 8, 11);
  endtask

  task automatic test_stall_first;
    run_layer("stall_first", 9, 10);
  endtask

  task automatic test_back_to_back;
    int d1 = -1;
    int d2 = -1;
    int iss = 0;
    int first_after = -1;
    int bad_idle = 0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 60 && d2 < 0; cyc++) begin
      step;
      if (issue) begin
        iss++;
        if (d1 > 0 && first_after < 0) first_after = cyc;
      end
      if (done) begin
        if (d1 < 0) d1 = cyc;
        else begin
          d2 = cyc;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step;
      if (issue || busy || done) bad_idle++;
    end
    n_cmp++;
    if (d1 !== 16) begin n_bad++; $display("FAIL b2b_done1: got %0d want 16", d1); end
    n_cmp++;
    if (d2 !== 32) begin n_bad++; $display("FAIL b2b_done2: got %0d want 32", d2); end
    n_cmp++;
    if (first_after !== d1 + 2) begin n_bad++; $display("FAIL b2b_restart: got %0d want %0d", first_after, d1 + 2); end
    n_cmp++;
    if (iss !== 24) begin n_bad++; $display("FAIL b2b_issues: got %0d want 24", iss); end
    n_cmp++;
    if (bad_idle !== 0) begin n_bad++; $display("FAIL b2b_idle: got %0d active cycles want 0", bad_idle); end
  endtask

  task automatic test_reset_abort;
    int found = 0;
    int stray = 0;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      step;
      if (issue && weight_addr == 16'h106) found = 1;
    end
    n_cmp++;
    if (found !== 1) begin n_bad++; $display("FAIL abort_reach_issue7: got %0d want 1", found); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({issue, reset_mult_acc, last_in, busy, done, in_addr, out_neuron_addr, weight_addr} !== '0) begin
      n_bad++;
      $display("FAIL abort_async_clear: got iss=%b busy=%b in=%h out=%h w=%h, want all 0",
               issue, busy, in_addr, out_neuron_addr, weight_addr);
    end
    step;
    step;
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step;
      if (done || issue || busy) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d active cycles want 0", stray); end
    run_layer("after_reset", 0, 0);
  endtask

  task automatic test_small;
    int k = 0;
    int last_iss = -1;
    int dc = -1;
    s_start = 1'b1;
    step;
    s_start = 1'b0;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      step;
      if (s_issue) begin
        n_cmp++;
        if (k == 0) begin
          if ({s_in_addr, s_weight_addr, s_reset_mult_acc, s_last_in, s_out_neuron_addr} !==
              {12'd0, 16'h100, 1'b1, 1'b0, 12'd0}) begin
            n_bad++;
            $display("FAIL small_issue1: got in=%h w=%h rst=%b last=%b, want in=0 w=0100 rst=1 last=0",
                     s_in_addr, s_weight_addr, s_reset_mult_acc, s_last_in);
          end
        end else begin
          if ({s_in_addr, s_weight_addr, s_reset_mult_acc, s_last_in, s_out_neuron_addr} !==
              {12'd1, 16'h101, 1'b0, 1'b1, 12'd0}) begin
            n_bad++;
            $display("FAIL small_issue%0d: got in=%h w=%h rst=%b last=%b, want in=1 w=0101 rst=0 last=1",
                     k + 1, s_in_addr, s_weight_addr, s_reset_mult_acc, s_last_in);
          end
        end
        k++;
        last_iss = cyc + 1;
      end
      if (s_done && dc < 0) dc = cyc + 1;
    end
    n_cmp++;
    if (k !== 2) begin n_bad++; $display("FAIL small_count: got %0d want 2", k); end
    n_cmp++;
    if (dc - last_iss !== 2) begin n_bad++; $display("FAIL small_done_gap: got %0d want 2", dc - last_iss); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall_mid;
    test_stall_first;
    test_back_to_back;
    test_reset_abort;
    test_small;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
